// File: rtl/phj_pkg.sv
// Shared probe-phase types for the partitioned hash join: lane count, beat
// numbers and the per-lane completion token layout.
package phj_pkg;

   localparam int LANES = 8;

   typedef logic [31:0] sn_t;

   // Also carried on the splitter's serial-number output.
   typedef struct packed {
      logic [31:0] lane;
      sn_t         sn;
   } lane_token_t;

endpackage

// File: rtl/probe_sn_tracker_if.sv
// Completion-token and end-of-phase bundle between the probe lanes/splitter
// (master) and the serial-number tracker (slave).
interface probe_sn_tracker_if;
   import phj_pkg::*;

   logic [LANES-1:0]        in_done_valid;
   lane_token_t [LANES-1:0] in_done_sn;
   logic [LANES-1:0]        in_done_ready;
   logic                    in_last_PROBE;
   sn_t                     in_total_beats;
   sn_t                     curr_sn;
   logic                    out_probe_done;
   logic                    out_err;

   modport master (
      output in_done_valid, in_done_sn, in_last_PROBE, in_total_beats,
      input  in_done_ready, curr_sn, out_probe_done, out_err
   );

   modport slave (
      input  in_done_valid, in_done_sn, in_last_PROBE, in_total_beats,
      output in_done_ready, curr_sn, out_probe_done, out_err
   );

endinterface

// File: rtl/sn_scoreboard_row.sv
// One scoreboard row: a completion bit per lane, all-ones detect, and a clear
// that wins over any same-cycle set.
module sn_scoreboard_row
   import phj_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] set_mask,
   input  logic             clr,
   output logic [LANES-1:0] bits,
   output logic             full
);

   // NOTE: the scoreboard is only a few flops, so it is reset like any other
   // state; a retire decision must never see stale bits after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bits <= '0;
      end else if (clr) begin
         // NOTE: non-blocking assignment for every flop so all rows and the
         // retire pointer update together from the same pre-edge values.
         bits <= '0;
      end else begin
         bits <= bits | set_mask;
      end
   end

   assign full = &bits;

endmodule

// File: rtl/probe_sn_tracker.sv
// Probe-phase completion tracker: retires beats in order as all lanes report.
// Define PROBE_SN_TRACKER_ERR_CHECK_EN to build the sticky protocol-error flag.
module probe_sn_tracker
   import phj_pkg::*;
#(
   parameter int MAX_IN_TRANSIT = 2
) (
   input logic               clk,
   input logic               reset,
   probe_sn_tracker_if.slave bus
);

   localparam int  IDX_W  = $clog2(MAX_IN_TRANSIT);
   localparam sn_t WINDOW = sn_t'(MAX_IN_TRANSIT);

   sn_t                                 curr_q;
   sn_t                                 total_q;
   logic                                last_seen_q;
   logic                                done_q;
   logic [MAX_IN_TRANSIT-1:0][LANES-1:0] row_bits;
   logic [MAX_IN_TRANSIT-1:0][LANES-1:0] row_set;
   logic [MAX_IN_TRANSIT-1:0]            row_full;
   logic [MAX_IN_TRANSIT-1:0]            row_clr;
   logic [LANES-1:0][IDX_W-1:0]          lane_idx;
   logic [LANES-1:0]                     tok_ok;
   logic [IDX_W-1:0]                     curr_idx;
   logic                                 retire;

`ifdef PROBE_SN_TRACKER_ERR_CHECK_EN
   logic [LANES-1:0] tok_bad;
   logic             err_q;
`endif

   assign curr_idx = curr_q[IDX_W-1:0];
   assign retire   = row_full[curr_idx];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_token_t tok;
      logic        in_win;
      logic        lane_ok;
      logic        already;

      assign tok         = bus.in_done_sn[i];
      assign lane_idx[i] = tok.sn[IDX_W-1:0];
      // Unsigned distance from the window base also covers wrap at 2^32.
      assign in_win      = (tok.sn - curr_q) < WINDOW;
      assign lane_ok     = (tok.lane == 32'(i));
      assign already     = row_bits[lane_idx[i]][i];
      assign tok_ok[i]   = bus.in_done_valid[i] & in_win & lane_ok & ~already;
`ifdef PROBE_SN_TRACKER_ERR_CHECK_EN
      assign tok_bad[i]  = bus.in_done_valid[i] & ~(in_win & lane_ok & ~already);
`endif
   end

   // NOTE: every variable gets its default first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      row_set = '0;
      for (int i = 0; i < LANES; i++) begin
         if (tok_ok[i]) row_set[lane_idx[i]][i] = 1'b1;
      end
   end

   for (genvar r = 0; r < MAX_IN_TRANSIT; r++) begin : g_row
      assign row_clr[r] = retire && (curr_idx == IDX_W'(r));

      sn_scoreboard_row u_row (
         .clk      (clk),
         .reset    (reset),
         .set_mask (row_set[r]),
         .clr      (row_clr[r]),
         .bits     (row_bits[r]),
         .full     (row_full[r])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curr_q      <= '0;
         total_q     <= '0;
         last_seen_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if (retire) curr_q <= curr_q + 32'd1;
         // Only the first cycle of in_last_PROBE matters until the next reset.
         if (bus.in_last_PROBE && !last_seen_q) begin
            last_seen_q <= 1'b1;
            total_q     <= bus.in_total_beats;
         end
         done_q <= done_q | (last_seen_q && (curr_q == total_q));
      end
   end

`ifdef PROBE_SN_TRACKER_ERR_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | (|tok_bad)
                  | (bus.in_last_PROBE && !last_seen_q && (bus.in_total_beats < curr_q));
      end
   end
   assign bus.out_err = err_q;
`else
   assign bus.out_err = 1'b0;
`endif

   assign bus.in_done_ready  = {LANES{~reset}};
   assign bus.curr_sn        = curr_q;
   assign bus.out_probe_done = done_q;

endmodule
